adxl362_spi_responder: RTL and testbench



---
 rtl/adxl362_spi_responder.sv | 169 ++++++++++++++++
 tb/tb_adxl362_spi_responder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adxl362_spi_responder.sv
// SPI mode-0 slave modelling the ADXL362 register interface.
// Commands 0x0A (write) / 0x0B (read), address byte, auto-increment data.
module adxl362_spi_responder #(
    parameter int                ADDR_W = 6,
    parameter logic [7:0]        DEVID  = 8'hAD,
    parameter logic [ADDR_W-1:0] RO_TOP = 'h0F
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              mosi,
    input  logic              ncs,
    output logic              miso,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [7:0]        host_wdata,
    output logic              wr_strobe,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CMD  = 3'd1;
    localparam logic [2:0] S_ADDR = 3'd2;
    localparam logic [2:0] S_DATA = 3'd3;
    localparam logic [2:0] S_IGN  = 3'd4;

    logic [2:0]        sclk_q;
    logic [1:0]        mosi_q;
    logic [1:0]        ncs_q;
    logic              rise;
    logic              fall;
    logic              mosi_s;
    logic              ncs_s;

    logic [2:0]        state;
    logic              rd;
    logic              load_pending;
    logic [2:0]        bit_cnt;
    logic [6:0]        rx;
    logic [7:0]        tx;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        mem [DEPTH];

    logic              byte_done;
    logic [7:0]        byte_val;

    // Two-flop synchronizers; the extra sclk flop gives edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_q <= 3'b000;
            mosi_q <= 2'b00;
            ncs_q  <= 2'b11;
        end else begin
            sclk_q <= {sclk_q[1:0], sclk};
            mosi_q <= {mosi_q[0], mosi};
            ncs_q  <= {ncs_q[0], ncs};
        end
    end

    assign rise      = sclk_q[1] & ~sclk_q[2];
    assign fall      = ~sclk_q[1] & sclk_q[2];
    assign mosi_s    = mosi_q[1];
    assign ncs_s     = ncs_q[1];
    assign byte_done = rise && (bit_cnt == 3'd7);
    assign byte_val  = {rx, mosi_s};

    // Transaction decoder, shifters and register file.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            rd           <= 1'b0;
            load_pending <= 1'b0;
            bit_cnt      <= 3'd0;
            rx           <= 7'd0;
            tx           <= 8'd0;
            addr         <= '0;
            wr_strobe    <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= 8'd0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= (i == 0) ? DEVID : 8'h00;
            end
        end else begin
            wr_strobe <= 1'b0;

            // Host write first so a same-cycle SPI write overrides it.
            if (host_we) begin
                mem[host_addr] <= host_wdata;
            end

            if (ncs_s) begin
                state        <= S_IDLE;
                bit_cnt      <= 3'd0;
                load_pending <= 1'b0;
            end else begin
                if (rise) begin
                    rx      <= byte_val[6:0];
                    bit_cnt <= bit_cnt + 3'd1;
                end

                if (fall && state == S_DATA && rd) begin
                    if (load_pending) begin
                        tx           <= mem[addr];
                        load_pending <= 1'b0;
                    end else begin
                        tx <= {tx[6:0], 1'b0};
                    end
                end

                unique case (state)
                    S_IDLE: begin
                        state <= S_CMD;
                    end
                    S_CMD: begin
                        if (byte_done) begin
                            unique case (byte_val)
                                8'h0B: begin
                                    rd    <= 1'b1;
                                    state <= S_ADDR;
                                end
                                8'h0A: begin
                                    rd    <= 1'b0;
                                    state <= S_ADDR;
                                end
                                default: state <= S_IGN;
                            endcase
                        end
                    end
                    S_ADDR: begin
                        if (byte_done) begin
                            addr  <= byte_val[ADDR_W-1:0];
                            state <= S_DATA;
                            if (rd) begin
                                load_pending <= 1'b1;
                            end
                        end
                    end
                    S_DATA: begin
                        if (byte_done) begin
                            addr <= addr + ADDR_W'(1);
                            if (rd) begin
                                load_pending <= 1'b1;
                            end else if (addr > RO_TOP) begin
                                mem[addr] <= byte_val;
                                wr_strobe <= 1'b1;
                                wr_addr   <= addr;
                                wr_data   <= byte_val;
                            end
                        end
                    end
                    S_IGN: begin
                        state <= S_IGN;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign miso = (state == S_DATA && rd) ? tx[7] : 1'b0;
    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_adxl362_spi_responder.sv
// Directed bench for adxl362_spi_responder.
// Read data and write strobes are checked through expectation queues.
module tb_adxl362_spi_responder;

    localparam int HALF = 8;

    logic       clk;
    logic       rst;
    logic       sclk;
    logic       mosi;
    logic       ncs;
    logic       miso;
    logic       host_we;
    logic [5:0] host_addr;
    logic [7:0] host_wdata;
    logic       wr_strobe;
    logic [5:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mdl [64];
    logic [7:0]  exp_rd [$];
    logic [13:0] exp_wr [$];

    adxl362_spi_responder dut (
        .clk        (clk),
        .rst        (rst),
        .sclk       (sclk),
        .mosi       (mosi),
        .ncs        (ncs),
        .miso       (miso),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .wr_strobe  (wr_strobe),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, obs, exp);
        end
    endtask

    // Every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (!rst && wr_strobe) begin
            if (exp_wr.size() == 0) begin
                check("wr_unexpected", {26'd0, wr_addr}, 32'hFFFF);
            end else begin
                logic [13:0] e;
                e = exp_wr.pop_front();
                check("wr_addr", {26'd0, wr_addr}, {26'd0, e[13:8]});
                check("wr_data", {24'd0, wr_data}, {24'd0, e[7:0]});
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < 64; i++) mdl[i] = 8'h00;
        mdl[0] = 8'hAD;
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bits(input logic [7:0] b, input int n,
                            output logic [7:0] r);
        r = 8'h00;
        for (int i = 7; i > 7 - n; i--) begin
            mosi = b[i];
            wait_clk(HALF);
            r[i] = miso;
            sclk = 1'b1;
            wait_clk(HALF);
            sclk = 1'b0;
        end
    endtask

    task automatic spi_byte(input logic [7:0] b, output logic [7:0] r);
        spi_bits(b, 8, r);
    endtask

    task automatic cs_low();
        ncs = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic cs_high();
        ncs = 1'b1;
        wait_clk(HALF);
    endtask

    task automatic host_write(input logic [5:0] a, input logic [7:0] d);
        host_addr  = a;
        host_wdata = d;
        host_we    = 1'b1;
        wait_clk(1);
        host_we    = 1'b0;
        mdl[a]     = d;
    endtask

    task automatic spi_write(input logic [5:0] a, input logic [7:0] d0,
                             input logic [7:0] d1, input int n);
        logic [7:0] r;
        logic [5:0] ai;
        logic [7:0] d;
        cs_low();
        spi_byte(8'h0A, r);
        spi_byte({2'b00, a}, r);
        ai = a;
        for (int i = 0; i < n; i++) begin
            d = (i == 0) ? d0 : d1;
            if (ai > 6'h0F) begin
                mdl[ai] = d;
                exp_wr.push_back({ai, d});
            end
            spi_byte(d, r);
            ai = ai + 6'd1;
        end
        cs_high();
    endtask

    task automatic spi_read(input logic [5:0] a, input int n);
        logic [7:0] r;
        logic [7:0] e;
        logic [5:0] ai;
        cs_low();
        spi_byte(8'h0B, r);
        spi_byte({2'b00, a}, r);
        ai = a;
        for (int i = 0; i < n; i++) begin
            exp_rd.push_back(mdl[ai]);
            spi_byte(8'h00, r);
            e = exp_rd.pop_front();
            check($sformatf("rd_%02h", ai), {24'd0, r}, {24'd0, e});
            ai = ai + 6'd1;
        end
        cs_high();
    endtask

    initial begin
        logic [7:0] r;
        rst        = 1'b1;
        sclk       = 1'b0;
        mosi       = 1'b0;
        ncs        = 1'b1;
        host_we    = 1'b0;
        host_addr  = 6'd0;
        host_wdata = 8'd0;
        model_reset();
        wait_clk(4);
        check("rst_miso", {31'd0, miso}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_strobe", {31'd0, wr_strobe}, 32'd0);
        check("rst_wr_addr", {26'd0, wr_addr}, 32'd0);
        check("rst_wr_data", {24'd0, wr_data}, 32'd0);
        rst = 1'b0;
        wait_clk(4);

        // Read DEVID with busy timing.
        cs_low();
        check("busy_cs", {31'd0, busy}, 32'd1);
        spi_byte(8'h0B, r);
        spi_byte(8'h00, r);
        check("busy_mid", {31'd0, busy}, 32'd1);
        spi_byte(8'h00, r);
        check("devid", {24'd0, r}, 32'hAD);
        ncs = 1'b1;
        wait_clk(2);
        check("busy_2clk", {31'd0, busy}, 32'd1);
        wait_clk(1);
        check("busy_3clk", {31'd0, busy}, 32'd0);
        wait_clk(HALF);

        // Burst write with two strobes, then read back.
        spi_write(6'h20, 8'h55, 8'h66, 2);
        spi_read(6'h20, 2);

        // Host-preloaded sensor values read by two transactions.
        host_write(6'h14, 8'h34);
        host_write(6'h15, 8'h12);
        spi_read(6'h14, 1);
        spi_read(6'h15, 1);

        // Protected address, then wrap from 0x3F into protected 0x00.
        spi_write(6'h05, 8'hFF, 8'h00, 1);
        spi_read(6'h05, 1);
        spi_write(6'h3F, 8'h11, 8'h22, 2);
        spi_read(6'h3F, 2);

        // Abort half-way through a write data byte.
        cs_low();
        spi_byte(8'h0A, r);
        spi_byte(8'h30, r);
        spi_bits(8'hCC, 4, r);
        cs_high();
        check("abort_busy", {31'd0, busy}, 32'd0);
        spi_read(6'h30, 1);

        // Unknown command is ignored and miso stays low.
        cs_low();
        spi_byte(8'h0D, r);
        check("bad_cmd_miso0", {24'd0, r}, 32'd0);
        spi_byte(8'h20, r);
        check("bad_cmd_miso1", {24'd0, r}, 32'd0);
        check("bad_cmd_busy", {31'd0, busy}, 32'd1);
        spi_byte(8'hAA, r);
        check("bad_cmd_miso2", {24'd0, r}, 32'd0);
        cs_high();
        spi_read(6'h20, 1);

        // Reset in the middle of a read data byte.
        cs_low();
        spi_byte(8'h0B, r);
        spi_byte(8'h20, r);
        spi_bits(8'h00, 4, r);
        rst = 1'b1;
        wait_clk(1);
        check("midrst_miso", {31'd0, miso}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        ncs = 1'b1;
        wait_clk(3);
        rst = 1'b0;
        model_reset();
        wait_clk(4);
        spi_read(6'h20, 1);
        spi_read(6'h00, 1);

        wait_clk(4);
        check("wr_pending", exp_wr.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
